// File: rtl/pipe_hazard_ctrl_if.sv
// Request/status bundle between a pipeline core (master) and its hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int NSTAGES = 5,
    parameter int CNT_W   = 32,
    parameter int SEL_W   = $clog2(NSTAGES)
);
    logic [NSTAGES-1:0] src_stall;
    logic               freeze;
    logic               redir_valid;
    logic [SEL_W-1:0]   redir_stage;
    logic               clear_cnt;
    logic [SEL_W-1:0]   cnt_sel;
    logic [NSTAGES-1:0] stall;
    logic [NSTAGES-1:0] flush;
    logic [NSTAGES-1:0] flush_pending;
    logic [CNT_W-1:0]   cnt_data;
    logic               wdog_trip;

    modport master (
        output src_stall, freeze, redir_valid, redir_stage, clear_cnt, cnt_sel,
        input  stall, flush, flush_pending, cnt_data, wdog_trip
    );

    modport slave (
        input  src_stall, freeze, redir_valid, redir_stage, clear_cnt, cnt_sel,
        output stall, flush, flush_pending, cnt_data, wdog_trip
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for an N-stage in-order pipeline with pending-flush
// tracking, per-stage stall counters and a fetch-stall watchdog.
module pipe_hazard_ctrl #(
    parameter int NSTAGES    = 5,
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 1024,
    parameter int SEL_W      = $clog2(NSTAGES)
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int WDOG_W = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

    logic [NSTAGES-1:0] stall_raw;
    logic [NSTAGES-1:0] target_now;
    logic [NSTAGES-1:0] flush_raw;
    logic [NSTAGES-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q [NSTAGES];
    logic [CNT_W-1:0]   cnt_d [NSTAGES];
    logic [WDOG_W-1:0]  wcnt_q, wcnt_d;
    logic               trip_q, trip_d;
    logic               redir_in_range;
    logic               redir_stall;
    logic               redir_accept;
    logic [CNT_W-1:0]   cnt_mux;

    // A stage stalls if it or any older-in-pipeline (downstream) stage requests it.
    genvar gi;
    generate
        for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
            assign stall_raw[gi]  = bus.freeze | (|bus.src_stall[NSTAGES-1:gi]);
            assign target_now[gi] = redir_accept &&
                                    ({1'b0, bus.redir_stage} > (SEL_W+1)'(gi));
        end
    endgenerate

    assign redir_in_range = (bus.redir_stage != '0) &&
                            ({1'b0, bus.redir_stage} < (SEL_W+1)'(NSTAGES));

    always_comb begin
        redir_stall = 1'b0;
        cnt_mux     = '0;
        for (int i = 0; i < NSTAGES; i++) begin
            if (bus.redir_stage == SEL_W'(i)) redir_stall = stall_raw[i];
            if (bus.cnt_sel == SEL_W'(i))     cnt_mux     = cnt_q[i];
        end
    end

    assign redir_accept = bus.redir_valid && redir_in_range && !redir_stall;
    assign flush_raw    = (target_now | pend_q) & ~stall_raw;

    always_comb begin
        pend_d = (pend_q | (target_now & stall_raw)) & ~flush_raw;
        for (int i = 0; i < NSTAGES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.clear_cnt)
                cnt_d[i] = '0;
            else if (stall_raw[i] && (cnt_q[i] != '1))
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
        wcnt_d = '0;
        trip_d = trip_q;
        if (WDOG_LIMIT > 0 && stall_raw[0]) begin
            wcnt_d = (wcnt_q == WDOG_MAX) ? wcnt_q : wcnt_q + 1'b1;
            if (wcnt_d == WDOG_MAX) trip_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            wcnt_q <= '0;
            trip_q <= 1'b0;
            for (int i = 0; i < NSTAGES; i++) cnt_q[i] <= '0;
        end else begin
            pend_q <= pend_d;
            wcnt_q <= wcnt_d;
            trip_q <= trip_d;
            for (int i = 0; i < NSTAGES; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Reset forces the whole pipeline to hold with no bubbles.
    assign bus.stall         = reset ? '1 : stall_raw;
    assign bus.flush         = reset ? '0 : flush_raw;
    assign bus.flush_pending = pend_q;
    assign bus.cnt_data      = cnt_mux;
    assign bus.wdog_trip     = trip_q;
endmodule
